// File: rtl/count_monitor_if.sv
// Read side of a W-bit counter: the enable driven into the counter and the
// count it produces. The master drives both signals, which is either the
// counter together with its controller or a bench. The slave only observes
// them.
interface count_monitor_if #(
  parameter int W = 2
) ();

  logic         en;
  logic [W-1:0] c;

  modport master (output en, output c);
  modport slave  (input  en, input  c);

endinterface

// File: rtl/count_monitor.sv
// Passive step checker for a W-bit up or down counter.
//
// The monitor samples (en, c) on every rising edge. From the previous sample
// it predicts the next value of c. It flags mismatches with a one-cycle err
// pulse and declares lock after LOCK_N consecutive correct steps. It also
// keeps saturating counts of mismatches and of legal wrap-arounds.
//
// After a mismatch the monitor reloads its prediction base from the observed
// value, so one bad step yields one error rather than a chain of them.
module count_monitor #(
  parameter int W      = 2,
  parameter bit DOWN   = 1'b1,
  parameter int LOCK_N = 4
) (
  input  logic                  clk,
  input  logic                  rst,      // asynchronous, active-low
  count_monitor_if.slave        bus,
  input  logic                  clr,
  output logic                  locked,
  output logic                  err,
  output logic [W-1:0]          exp,
  output logic [7:0]            err_cnt,
  output logic [7:0]            wrap_cnt
);

  localparam logic [1:0] ST_UNSYNC  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [W-1:0] C_ZERO    = '0;
  localparam logic [W-1:0] C_ONE     = W'(1);
  localparam logic [W-1:0] C_MAX     = '1;
  localparam logic [3:0]   GOOD_LAST = 4'(LOCK_N - 1);
  localparam logic [3:0]   GOOD_MAX  = 4'hF;
  localparam logic [7:0]   CNT_MAX   = 8'hFF;

  logic [1:0]   state;
  logic [W-1:0] prev_c;
  logic         prev_en;
  logic [3:0]   good;

  logic [W-1:0] exp_c;
  logic         comparing;
  logic         match;
  logic         mismatch;
  logic         wrap_edge;
  logic         wrap_hit;

  // Predict the next sample and classify the current one against it.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    exp_c     = prev_c;
    wrap_edge = 1'b0;
    if (prev_en) begin
      exp_c = DOWN ? (prev_c - C_ONE) : (prev_c + C_ONE);
    end
    if (DOWN) begin
      wrap_edge = (prev_c == C_ZERO) && (bus.c == C_MAX);
    end else begin
      wrap_edge = (prev_c == C_MAX) && (bus.c == C_ZERO);
    end
    comparing = (state != ST_UNSYNC);
    match     = (bus.c == exp_c);
    mismatch  = comparing && !match;
    wrap_hit  = comparing && match && prev_en && wrap_edge;
  end

  // Lock state machine, with the previous-sample registers and the good-run counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register here sees pre-edge values of the others.
      state   <= ST_UNSYNC;
      prev_c  <= '0;
      prev_en <= 1'b0;
      good    <= '0;
    end else begin
      case (state)
        ST_UNSYNC: begin
          prev_c  <= bus.c;
          prev_en <= bus.en;
          good    <= '0;
          state   <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          prev_c  <= bus.c;
          prev_en <= bus.en;
          if (match) begin
            good <= good + 4'd1;
            if (good == GOOD_LAST) begin
              state <= ST_LOCKED;
            end
          end else begin
            good <= '0;
          end
        end
        ST_LOCKED: begin
          prev_c  <= bus.c;
          prev_en <= bus.en;
          if (match) begin
            if (good != GOOD_MAX) begin
              good <= good + 4'd1;
            end
          end else begin
            good  <= '0;
            state <= ST_ACQUIRE;
          end
        end
        default: begin
          state <= ST_UNSYNC;
        end
      endcase
    end
  end

  // One-cycle error pulse for each mismatching edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= mismatch;
    end
  end

  // Saturating event counters. A clear on an edge wins over an increment on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (clr) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      if (mismatch && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (wrap_hit && (wrap_cnt != CNT_MAX)) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign exp    = exp_c;

endmodule
